// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read at the committed PC, holds the
// fetched instruction for decode, then waits for execute to commit the next PC.
// A misaligned committed PC halts fetch until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] programCounterInput,
  input  logic        pcWriteEnable,
  output logic [31:0] memAddress,
  output logic        memRequest,
  input  logic        memAck,
  input  logic [31:0] memReadData,
  output logic [31:0] instruction,
  output logic [31:0] pcOfInstruction,
  output logic        instructionValid,
  input  logic        instructionReady,
  output logic        fetchMisaligned
);

  typedef enum logic [1:0] {REQUEST, HOLD, WAIT_PC, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, instr_q, pcof_q;
  logic        valid_q, misal_q;
  // Cleared by reset, set on the first edge after release: keeps memRequest low
  // while reset is held even though the state already sits in REQUEST.
  logic        live_q;

  logic take_fetch, pc_commit, pc_aligned;

  assign take_fetch = (state_q == REQUEST) && live_q && memAck;
  assign pc_commit  = (state_q == WAIT_PC) && pcWriteEnable;
  assign pc_aligned = (programCounterInput[1:0] == 2'b00);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= REQUEST;
    else        state_q <= state_d;
  end

  // Next-state logic; pcWriteEnable only matters in WAIT_PC
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQUEST: if (take_fetch)       state_d = HOLD;
      HOLD:    if (instructionReady) state_d = WAIT_PC;
      WAIT_PC: if (pcWriteEnable)    state_d = pc_aligned ? REQUEST : HALT;
      HALT:                          state_d = HALT;
      default:                       state_d = REQUEST;
    endcase
  end

  // Memory-side outputs, combinational from state and pc
  always_comb begin
    memRequest = (state_q == REQUEST) && live_q;
    memAddress = pc_q;
  end

  // PC, fetched instruction and status registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_q  <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pcof_q  <= 32'h0;
      valid_q <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (take_fetch) begin
        instr_q <= memReadData;
        pcof_q  <= pc_q;
        valid_q <= 1'b1;
      end else if (state_q == HOLD && instructionReady) begin
        valid_q <= 1'b0;
      end
      // No increment here: the next PC always comes from execute
      if (pc_commit) begin
        pc_q <= programCounterInput;
        if (!pc_aligned) misal_q <= 1'b1;
      end
    end
  end

  assign instruction      = instr_q;
  assign pcOfInstruction  = pcof_q;
  assign instructionValid = valid_q;
  assign fetchMisaligned  = misal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Stimulus pushes the expected {instruction, pc}
// pair when it returns memAck; a monitor pops and compares on each accepted
// decode handshake. Point checks cover memory-side outputs and halt/reset.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] programCounterInput;
  logic        pcWriteEnable;
  logic [31:0] memAddress;
  logic        memRequest;
  logic        memAck;
  logic [31:0] memReadData;
  logic [31:0] instruction;
  logic [31:0] pcOfInstruction;
  logic        instructionValid;
  logic        instructionReady;
  logic        fetchMisaligned;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .programCounterInput(programCounterInput), .pcWriteEnable(pcWriteEnable),
    .memAddress(memAddress), .memRequest(memRequest),
    .memAck(memAck), .memReadData(memReadData),
    .instruction(instruction), .pcOfInstruction(pcOfInstruction),
    .instructionValid(instructionValid), .instructionReady(instructionReady),
    .fetchMisaligned(fetchMisaligned)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Monitor: every accepted instruction must match the next scoreboard entry
  always @(negedge clock) begin
    if (reset && instructionValid && instructionReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h@%h expected nothing", instruction, pcOfInstruction);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_instr", instruction, e[63:32]);
        chk("sb_pc", pcOfInstruction, e[31:0]);
      end
    end
  end

  task automatic ack(input logic [31:0] data, input logic [31:0] pc);
    memAck = 1'b1;
    memReadData = data;
    exp_q.push_back({data, pc});
    tick();
    memAck = 1'b0;
    memReadData = 32'hx;
  endtask

  task automatic accept();
    instructionReady = 1'b1;
    tick();
    instructionReady = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    programCounterInput = 32'h0;
    pcWriteEnable = 1'b0;
    memAck = 1'b0;
    memReadData = 32'h0;
    instructionReady = 1'b0;

    // Reset state
    tick(); tick(); settle();
    chk("rst_memRequest", {31'b0, memRequest}, 32'd0);
    chk("rst_valid", {31'b0, instructionValid}, 32'd0);
    chk("rst_misaligned", {31'b0, fetchMisaligned}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pcof", pcOfInstruction, 32'h0);

    // Release between edges; request appears after the first rising edge
    reset = 1'b1;
    tick(); settle();
    chk("rel_memRequest", {31'b0, memRequest}, 32'd1);
    chk("rel_memAddress", memAddress, 32'h0);
    tick();
    chk("wait_memRequest", {31'b0, memRequest}, 32'd1);
    ack(32'h0050_0093, 32'h0);
    settle();
    chk("first_valid", {31'b0, instructionValid}, 32'd1);
    chk("first_instr", instruction, 32'h0050_0093);
    chk("first_pcof", pcOfInstruction, 32'h0);
    chk("hold_memRequest", {31'b0, memRequest}, 32'd0);

    // Hold for 5 cycles; a pcWriteEnable pulse here must be ignored
    for (int i = 0; i < 5; i++) begin
      pcWriteEnable = (i == 2);
      programCounterInput = 32'h0000_0200;
      tick(); settle();
      chk("hold_valid", {31'b0, instructionValid}, 32'd1);
      chk("hold_instr", instruction, 32'h0050_0093);
    end
    pcWriteEnable = 1'b0;
    chk("hold_pc_ignored", memAddress, 32'h0);
    accept(); settle();
    chk("accept_valid", {31'b0, instructionValid}, 32'd0);
    chk("waitpc_memRequest", {31'b0, memRequest}, 32'd0);

    // memAck in WAIT_PC must not load anything
    memAck = 1'b1; memReadData = 32'hDEAD_BEEF;
    tick(); memAck = 1'b0; settle();
    chk("waitpc_ack_instr", instruction, 32'h0050_0093);
    chk("waitpc_ack_valid", {31'b0, instructionValid}, 32'd0);

    // Aligned commit
    pcWriteEnable = 1'b1; programCounterInput = 32'h0000_0104;
    tick(); pcWriteEnable = 1'b0; settle();
    chk("commit_memRequest", {31'b0, memRequest}, 32'd1);
    chk("commit_memAddress", memAddress, 32'h0000_0104);

    // pcWriteEnable during REQUEST is ignored
    pcWriteEnable = 1'b1; programCounterInput = 32'h0000_0300;
    tick(); pcWriteEnable = 1'b0; settle();
    chk("req_pc_ignored", memAddress, 32'h0000_0104);
    ack(32'h00A0_0113, 32'h0000_0104);

    // pcWriteEnable coinciding with instructionReady in HOLD is ignored
    pcWriteEnable = 1'b1; programCounterInput = 32'h0000_0400;
    accept(); pcWriteEnable = 1'b0; settle();
    chk("coinc_memRequest", {31'b0, memRequest}, 32'd0);
    chk("coinc_pc_ignored", memAddress, 32'h0000_0104);
    pcWriteEnable = 1'b1; programCounterInput = 32'h0000_0108;
    tick(); pcWriteEnable = 1'b0; settle();
    chk("commit2_memAddress", memAddress, 32'h0000_0108);
    chk("commit2_memRequest", {31'b0, memRequest}, 32'd1);

    // Reset mid-request: request drops immediately, later ack is dropped
    reset = 1'b0;
    #1;
    chk("midrst_memRequest", {31'b0, memRequest}, 32'd0);
    memAck = 1'b1; memReadData = 32'h1111_1111;
    tick(); memAck = 1'b0; settle();
    chk("midrst_instr", instruction, 32'h0);
    chk("midrst_valid", {31'b0, instructionValid}, 32'd0);
    reset = 1'b1;
    tick(); settle();
    chk("restart_memRequest", {31'b0, memRequest}, 32'd1);
    chk("restart_memAddress", memAddress, 32'h0);
    ack(32'h2222_2222, 32'h0);
    accept();

    // Misaligned commit halts fetch
    pcWriteEnable = 1'b1; programCounterInput = 32'h0000_0102;
    tick(); pcWriteEnable = 1'b0; settle();
    chk("mis_flag", {31'b0, fetchMisaligned}, 32'd1);
    chk("mis_memRequest", {31'b0, memRequest}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pcWriteEnable = 1'b1; programCounterInput = 32'h0000_0200;
      memAck = 1'b1; memReadData = 32'h3333_3333;
      instructionReady = 1'b1;
      tick(); settle();
      chk("halt_memRequest", {31'b0, memRequest}, 32'd0);
      chk("halt_valid", {31'b0, instructionValid}, 32'd0);
      chk("halt_flag", {31'b0, fetchMisaligned}, 32'd1);
    end
    pcWriteEnable = 1'b0; memAck = 1'b0; instructionReady = 1'b0;
    chk("halt_instr", instruction, 32'h2222_2222);

    // Reset clears the halt
    reset = 1'b0;
    #1;
    chk("clr_flag", {31'b0, fetchMisaligned}, 32'd0);
    chk("clr_memRequest", {31'b0, memRequest}, 32'd0);
    tick();
    reset = 1'b1;
    tick(); settle();
    chk("clr_restart_req", {31'b0, memRequest}, 32'd1);
    chk("clr_restart_addr", memAddress, 32'h0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
